// File: rtl/regbank_wr_arb.sv
// Write-port arbiter and clear sequencer in front of the 32 x 32 register bank.
// Optional feature macro: REGARB_R0_ZERO_EN (register 0 hardwired to zero).
module regbank_wr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               rf_write,
  output logic [AW-1:0]      rf_dr,
  output logic [DW-1:0]      rf_wrData
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] CNT_LAST = '1;
`ifdef REGARB_R0_ZERO_EN
  localparam logic [AW-1:0] CNT_FIRST = AW'(1);
  localparam bit            R0_ZERO   = 1'b1;
`else
  localparam logic [AW-1:0] CNT_FIRST = AW'(0);
  localparam bit            R0_ZERO   = 1'b0;
`endif

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_write_q, rf_write_d;
  logic [AW-1:0]   rf_dr_q, rf_dr_d;
  logic [DW-1:0]   rf_wrdata_q, rf_wrdata_d;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     cand_sum;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand_sum >= (PW+1)'(NREQ)) begin
        cand_sum = cand_sum - (PW+1)'(NREQ);
      end
      if (!gnt_found && req_valid[cand_sum[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_sum[PW-1:0];
      end
    end
  end

  assign gnt_addr = req_addr[32'(gnt_idx)*AW +: AW];
  assign gnt_data = req_data[32'(gnt_idx)*DW +: DW];

  // Next-state, grant and output-stage load selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    req_ready   = '0;
    rf_write_d  = 1'b0;
    rf_dr_d     = rf_dr_q;
    rf_wrdata_d = rf_wrdata_q;

    unique case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = CNT_FIRST;
        end else if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
          if (!(R0_ZERO && (gnt_addr == '0))) begin
            rf_write_d  = 1'b1;
            rf_dr_d     = gnt_addr;
            rf_wrdata_d = gnt_data;
          end
        end
      end
      CLEAR: begin
        rf_write_d  = 1'b1;
        rf_dr_d     = cnt_q;
        rf_wrdata_d = '0;
        if (cnt_q == CNT_LAST) begin
          state_d = ARB;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = ARB;
    endcase

    // No grant may be seen during the reset cycle.
    if (reset) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rf_write_q  <= 1'b0;
      rf_dr_q     <= '0;
      rf_wrdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rf_write_q  <= rf_write_d;
      rf_dr_q     <= rf_dr_d;
      rf_wrdata_q <= rf_wrdata_d;
    end
  end

  assign clear_busy = (state_q == CLEAR);
  assign rf_write   = rf_write_q;
  assign rf_dr      = rf_dr_q;
  assign rf_wrData  = rf_wrdata_q;

endmodule

// File: tb/tb_regbank_wr_arb.sv
// Randomized, model-checked bench for regbank_wr_arb, with directed scenarios
// and a shadow register bank fed from the DUT's write port.
module tb_regbank_wr_arb;
  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
`ifdef REGARB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif
  localparam int CLR_LEN = R0Z ? DEPTH - 1 : DEPTH;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               clear_start;
  logic               clear_busy;
  logic               rf_write;
  logic [AW-1:0]      rf_dr;
  logic [DW-1:0]      rf_wrData;

  logic [AW-1:0] s_addr [NREQ];
  logic [DW-1:0] s_data [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = s_addr[i];
      req_data[i*DW +: DW] = s_data[i];
    end
  end

  regbank_wr_arb #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clear_start(clear_start),
    .clear_busy(clear_busy), .rf_write(rf_write), .rf_dr(rf_dr), .rf_wrData(rf_wrData)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: abstract state plus predicted output-stage contents.
  bit            m_live = 1'b0;
  int            m_ptr, m_cnt, m_last_gnt = -1;
  bit            m_clr, m_rfw;
  logic [AW-1:0] m_dr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] mbank [DEPTH];
  logic [DW-1:0] dbank [DEPTH];

  always @(negedge clk) begin
    int g;
    int idx;
    logic [NREQ-1:0] er;
    logic [AW-1:0] a;
    if (rf_write) dbank[rf_dr] = rf_wrData;
    if (m_live && m_rfw) mbank[m_dr] = m_data;
    g  = -1;
    er = '0;
    if (!reset && !m_clr && !clear_start) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    if (m_live) begin
      chk("req_ready", longint'(req_ready), longint'(er));
      chk("clear_busy", longint'(clear_busy), longint'(m_clr));
      chk("rf_write", longint'(rf_write), longint'(m_rfw));
      chk("rf_dr", longint'(rf_dr), longint'(m_dr));
      chk("rf_wrData", longint'(rf_wrData), longint'(m_data));
    end
    m_last_gnt = g;
    if (reset) begin
      m_live = 1'b1; m_ptr = 0; m_clr = 1'b0; m_cnt = 0;
      m_rfw = 1'b0; m_dr = '0; m_data = '0;
    end else if (m_clr) begin
      m_rfw = 1'b1; m_dr = AW'(m_cnt); m_data = '0;
      if (m_cnt == DEPTH - 1) m_clr = 1'b0;
      else m_cnt++;
    end else if (clear_start) begin
      m_clr = 1'b1; m_cnt = R0Z ? 1 : 0; m_rfw = 1'b0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      a = req_addr[g*AW +: AW];
      if (R0Z && a == '0) m_rfw = 1'b0;
      else begin
        m_rfw = 1'b1; m_dr = a; m_data = req_data[g*DW +: DW];
      end
    end else begin
      m_rfw = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] pre [DEPTH];

  // Fill every register with a random value through requester 0.
  task automatic preload();
    for (int a = 0; a < DEPTH; a++) begin
      req_valid = 4'b0001;
      s_addr[0] = AW'(a);
      s_data[0] = $urandom;
      pre[a]    = (R0Z && a == 0) ? '0 : s_data[0];
      cyc();
    end
    req_valid = '0;
    cyc();
  endtask

  initial begin
    int zeros, busy, found;
    reset = 1'b1; clear_start = 1'b0; req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin s_addr[i] = '0; s_data[i] = '0; end
    for (int i = 0; i < DEPTH; i++) begin mbank[i] = '0; dbank[i] = '0; end
    repeat (3) cyc();
    #2;
    chk("reset req_ready", longint'(req_ready), 0);
    chk("reset rf_write", longint'(rf_write), 0);
    chk("reset rf_dr", longint'(rf_dr), 0);
    chk("reset rf_wrData", longint'(rf_wrData), 0);
    chk("reset clear_busy", longint'(clear_busy), 0);
    cyc();
    reset = 1'b0; req_valid = '0;
    cyc();

    // Single request: same-cycle grant, next-cycle write, then bank holds it.
    req_valid = 4'b0001; s_addr[0] = 5'd7; s_data[0] = 32'hDEADBEEF;
    #2; chk("single ready", longint'(req_ready), 1);
    cyc(); req_valid = '0;
    chk("single rf_write", longint'(rf_write), 1);
    chk("single rf_dr", longint'(rf_dr), 7);
    chk("single rf_wrData", longint'(rf_wrData), 32'hDEADBEEF);
    cyc();
    chk("single bank[7]", longint'(dbank[7]), 32'hDEADBEEF);

    // Bring ptr back to 0, then all four compete for 8 cycles.
    req_valid = 4'b1000; cyc();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      s_addr[i % 4] = AW'(i + 1); s_data[i % 4] = 32'(i);
      #2; chk("rr grant", longint'(req_ready), longint'(1 << (i % 4)));
      cyc();
      chk("rr rf_write", longint'(rf_write), 1);
    end
    req_valid = '0;

    // Pointer skip: ptr=2 after granting requester 1; 1 and 3 valid.
    req_valid = 4'b0010; cyc();
    req_valid = 4'b1010;
    #2; chk("skip g0", longint'(req_ready), 4'b1000); cyc();
    #2; chk("skip g1", longint'(req_ready), 4'b0010); cyc();
    #2; chk("skip g2", longint'(req_ready), 4'b1000); cyc();
    req_valid = '0;

    // Clear against a pending request.
    preload();
    req_valid = 4'b0010; s_addr[1] = 5'd20; s_data[1] = 32'h55; clear_start = 1'b1;
    zeros = 0; busy = 0; found = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (req_ready != 0) begin found = 1; break; end
      zeros++;
      if (clear_busy) busy++;
      cyc(); clear_start = 1'b0;
    end
    chk("clear found grant", longint'(found), 1);
    chk("clear ready-zero cycles", longint'(zeros), longint'(CLR_LEN + 1));
    chk("clear busy cycles", longint'(busy), longint'(CLR_LEN));
    chk("clear grant r1", longint'(req_ready), 4'b0010);
    cyc(); req_valid = '0;
    for (int a = 0; a < DEPTH; a++) chk($sformatf("clear bank[%0d]", a), longint'(dbank[a]), 0);
    cyc();

    // Reset in the middle of a clear, right after the write to address 10.
    preload();
    clear_start = 1'b1; cyc(); clear_start = 1'b0;
    found = 0;
    for (int i = 0; i < 64; i++) begin
      if (rf_write && rf_dr == 5'd10) begin found = 1; break; end
      cyc();
    end
    chk("midclear reached addr 10", longint'(found), 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("midclear clear_busy", longint'(clear_busy), 0);
    chk("midclear rf_write", longint'(rf_write), 0);
    req_valid = 4'b0001; s_addr[0] = 5'd11; s_data[0] = pre[11];
    #2; chk("midclear arb grant", longint'(req_ready), 1);
    cyc(); req_valid = '0; cyc();
    for (int a = 0; a < DEPTH; a++)
      chk($sformatf("midclear bank[%0d]", a), longint'(dbank[a]), longint'(a <= 10 ? 32'd0 : pre[a]));

    // Write to address 0 from requester 2.
    req_valid = 4'b0100; s_addr[2] = '0; s_data[2] = 32'h1234;
    #2; chk("r0 ready", longint'(req_ready), 4'b0100);
    cyc(); req_valid = '0;
    chk("r0 rf_write", longint'(rf_write), R0Z ? 0 : 1);
    cyc();
    chk("r0 bank[0]", longint'(dbank[0]), R0Z ? 0 : 32'h1234);

    // Randomized traffic honouring the stable-while-valid rule.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && m_last_gnt != i) begin
          if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'($urandom_range(1));
          s_addr[i] = AW'($urandom);
          s_data[i] = $urandom;
        end
      end
      clear_start = ($urandom_range(199) == 0);
      reset       = ($urandom_range(499) == 0);
      cyc();
    end
    reset = 1'b0; clear_start = 1'b0; req_valid = '0;
    repeat (40) cyc();
    for (int a = 0; a < DEPTH; a++)
      chk($sformatf("final bank[%0d]", a), longint'(dbank[a]), longint'(mbank[a]));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
